// File: rtl/enable_map.sv
// Chip-select decoder for the 6502-side bus: a table of enable flags is indexed by
// {configuration, rwbar, address region} and looked up once per phi2 bus cycle.
module enable_map #(
    parameter int ADDR_WIDTH       = 16,
    parameter int GRANULARITY_BITS = 8,
    parameter int CONFIG_BITS      = 5,
    parameter int NUM_FLAGS        = 2,
    parameter logic [NUM_FLAGS-1:0] DEFAULT_FLAGS = '0,
    localparam int REGION_BITS     = ADDR_WIDTH - GRANULARITY_BITS,
    localparam int TABLE_ADDR_BITS = CONFIG_BITS + 1 + REGION_BITS
) (
    input  logic                       fpga_clk,
    input  logic                       reset,
    input  logic                       phi2,
    input  logic                       rwbar,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic [CONFIG_BITS-1:0]     configuration,
    input  logic                       config_load,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [TABLE_ADDR_BITS-1:0] wr_addr,
    input  logic [NUM_FLAGS-1:0]       wr_data,
    output logic [NUM_FLAGS-1:0]       enables,
    output logic                       we,
    output logic                       table_ready
);

    localparam int TABLE_DEPTH = 2 ** TABLE_ADDR_BITS;
    localparam logic [TABLE_ADDR_BITS-1:0] INIT_LAST = '1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_HOLD
    } state_e;

    state_e                      state_q;
    logic                        phi2_meta_q;
    logic                        phi2_sync_q;
    logic                        phi2_prev_q;
    logic                        rise_det;
    logic                        fall_det;
    logic [CONFIG_BITS-1:0]      pending_cfg_q;
    logic [CONFIG_BITS-1:0]      active_cfg_q;
    logic                        rwbar_lat_q;
    logic [REGION_BITS-1:0]      region_lat_q;
    logic [TABLE_ADDR_BITS-1:0]  init_idx_q;
    logic [TABLE_ADDR_BITS-1:0]  lookup_idx;
    logic [TABLE_ADDR_BITS-1:0]  mem_waddr;
    logic [NUM_FLAGS-1:0]        mem_wdata;
    logic                        mem_we;
    logic                        wr_accept;
    logic [NUM_FLAGS-1:0]        enables_q;
    logic                        we_q;
    logic                        table_ready_q;
    logic [NUM_FLAGS-1:0]        table_q [TABLE_DEPTH];

    // Byte offset within a region never affects the lookup.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[GRANULARITY_BITS-1:0];

    // Stage: phi2 synchroniser and edge detector
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            phi2_meta_q <= 1'b0;
            phi2_sync_q <= 1'b0;
            phi2_prev_q <= 1'b0;
        end else begin
            phi2_meta_q <= phi2;
            phi2_sync_q <= phi2_meta_q;
            phi2_prev_q <= phi2_sync_q;
        end
    end

    assign rise_det = phi2_sync_q & ~phi2_prev_q;
    assign fall_det = ~phi2_sync_q & phi2_prev_q;

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            pending_cfg_q <= '0;
        end else if (config_load) begin
            pending_cfg_q <= configuration;
        end
    end

    // Stage: bus-cycle capture (data only, qualified by the FSM)
    always_ff @(posedge fpga_clk) begin
        if (state_q == ST_IDLE && rise_det) begin
            rwbar_lat_q  <= rwbar;
            region_lat_q <= address[ADDR_WIDTH-1:GRANULARITY_BITS];
        end
    end

    assign lookup_idx = {active_cfg_q, rwbar_lat_q, region_lat_q};

    // Writes are only offered while idle with phi2 low, so they can never race a lookup.
    assign wr_ready  = (state_q == ST_IDLE) && !phi2_sync_q;
    assign wr_accept = wr_valid && wr_ready;
    assign mem_we    = !reset && ((state_q == ST_INIT) || wr_accept);
    assign mem_waddr = (state_q == ST_INIT) ? init_idx_q : wr_addr;
    assign mem_wdata = (state_q == ST_INIT) ? DEFAULT_FLAGS : wr_data;

    always_ff @(posedge fpga_clk) begin
        if (mem_we) begin
            table_q[mem_waddr] <= mem_wdata;
        end
    end

    // Stage: control FSM with registered table read into the enables register
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            init_idx_q    <= '0;
            active_cfg_q  <= '0;
            enables_q     <= '0;
            we_q          <= 1'b0;
            table_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_idx_q <= init_idx_q + TABLE_ADDR_BITS'(1);
                    if (init_idx_q == INIT_LAST) begin
                        table_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (rise_det) begin
                        active_cfg_q <= pending_cfg_q;
                        state_q      <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (fall_det) begin
                        state_q <= ST_IDLE;
                    end else begin
                        enables_q <= table_q[lookup_idx];
                        we_q      <= ~rwbar_lat_q;
                        state_q   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (fall_det) begin
                        enables_q <= '0;
                        we_q      <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign enables     = enables_q;
    assign we          = we_q;
    assign table_ready = table_ready_q;

endmodule

// File: tb/tb_enable_map.sv
// Bench for enable_map: directed and randomised bus cycles checked against a
// table/latency model of the decoder.
module tb_enable_map;

    logic        fpga_clk = 1'b0;
    logic        reset = 1'b1;
    logic        phi2 = 1'b0;
    logic        rwbar = 1'b1;
    logic [15:0] address = '0;
    logic [4:0]  configuration = '0;
    logic        config_load = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [13:0] wr_addr = '0;
    logic [1:0]  wr_data = '0;
    logic [1:0]  enables;
    logic        we;
    logic        table_ready;

    int errors = 0;
    int checks = 0;

    logic [1:0] ref_tbl [16384];
    logic [4:0] pending_m;

    enable_map dut (
        .fpga_clk     (fpga_clk),
        .reset        (reset),
        .phi2         (phi2),
        .rwbar        (rwbar),
        .address      (address),
        .configuration(configuration),
        .config_load  (config_load),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .enables      (enables),
        .we           (we),
        .table_ready  (table_ready)
    );

    always #5 fpga_clk = ~fpga_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Releases reset, lets the table clear itself, and checks when it becomes ready.
    task automatic init_count();
        for (int i = 0; i < 16384; i++) ref_tbl[i] = 2'b00;
        pending_m = 5'd0;
        reset = 1'b0;
        for (int n = 1; n <= 16384; n++) begin
            tick();
            if (n == 100) phi2 = 1'b1;
            if (n == 110) phi2 = 1'b0;
            if (n == 200) begin
                config_load   = 1'b1;
                configuration = 5'd3;
            end
            if (n == 201) begin
                config_load = 1'b0;
                pending_m   = 5'd3;
            end
            if (n == 105 || n == 150 || n == 16383) begin
                chk("init_enables", enables, 0);
                chk("init_ready_low", table_ready, 0);
                chk("init_wr_ready", wr_ready, 0);
            end
            if (n == 16384) chk("init_ready_high", table_ready, 1);
        end
    endtask

    task automatic tbl_write(input logic [13:0] a, input logic [1:0] d);
        chk("wr_ready_idle", wr_ready, 1);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        ref_tbl[a] = d;
    endtask

    task automatic cfg_load(input logic [4:0] c);
        config_load   = 1'b1;
        configuration = c;
        tick();
        config_load = 1'b0;
        pending_m   = c;
    endtask

    // One phi2 bus cycle with phi2 sampled high for 'hi' clocks. Enables are due from
    // the 4th clock after the rise until 2 clocks after the fall edge clock.
    task automatic bus_cycle(input logic [15:0] addr, input logic rw, input int hi,
                             input logic load_at_rise, input logic [4:0] new_cfg,
                             input logic hold_wr, input logic [13:0] waddr,
                             input logic [1:0] wdata);
        logic [4:0]  active;
        logic [13:0] idx;
        logic [1:0]  exp_v;
        logic        on;
        logic        pend;
        active = pending_m;
        if (load_at_rise) pending_m = new_cfg;
        idx   = {active, rw, addr[15:8]};
        exp_v = ref_tbl[idx];
        pend  = 1'b0;
        address = addr;
        rwbar   = rw;
        phi2    = 1'b1;
        for (int k = 1; k <= hi + 6; k++) begin
            tick();
            if (pend) begin
                wr_valid = 1'b0;
                ref_tbl[waddr] = wdata;
                pend = 1'b0;
            end
            if (k == hi) phi2 = 1'b0;
            on = (hi >= 2) && (k >= 4) && (k <= hi + 2);
            chk("enables", enables, on ? exp_v : 2'b00);
            chk("we", we, on && !rw);
            chk("wr_ready", wr_ready, (k < 2) || (k >= hi + 3));
            if (load_at_rise && k == 2) begin
                config_load   = 1'b1;
                configuration = new_cfg;
            end
            if (load_at_rise && k == 3) config_load = 1'b0;
            if (hold_wr && k == 2) begin
                wr_valid = 1'b1;
                wr_addr  = waddr;
                wr_data  = wdata;
            end
            if (hold_wr && k == hi + 3) pend = 1'b1;
        end
    endtask

    task automatic bus(input logic [15:0] addr, input logic rw, input int hi);
        bus_cycle(addr, rw, hi, 1'b0, 5'd0, 1'b0, 14'd0, 2'b00);
    endtask

    initial begin
        logic       rw_r;
        logic [7:0] reg_r;
        int         hi_r;

        pending_m = 5'd0;
        repeat (3) tick();
        chk("rst_enables", enables, 0);
        chk("rst_we", we, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_table_ready", table_ready, 0);

        init_count();
        tick();

        // Unwritten entry reads back the cleared value.
        bus(16'h1234, 1'b1, 4);

        tbl_write({5'd3, 1'b1, 8'hC0}, 2'b10);
        bus(16'hC012, 1'b1, 6);

        tbl_write({5'd3, 1'b0, 8'h20}, 2'b11);
        bus(16'h20FF, 1'b0, 5);
        bus(16'h2155, 1'b0, 3);

        // Write held across a lookup of the same entry: old value now, new value next time.
        bus_cycle(16'hC012, 1'b1, 5, 1'b0, 5'd0, 1'b1, {5'd3, 1'b1, 8'hC0}, 2'b01);
        bus(16'hC012, 1'b1, 3);

        tbl_write({5'd7, 1'b1, 8'h40}, 2'b01);
        tbl_write({5'd3, 1'b1, 8'h40}, 2'b10);
        bus_cycle(16'h4000, 1'b1, 4, 1'b1, 5'd7, 1'b0, 14'd0, 2'b00);
        bus(16'h4000, 1'b1, 4);

        // Minimal phi2 pulse never reaches HOLD.
        bus(16'h4000, 1'b1, 1);
        bus(16'h4000, 1'b1, 2);

        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 2) == 0) cfg_load(5'($urandom));
            rw_r  = 1'($urandom);
            reg_r = 8'h80 + 8'($urandom_range(0, 3));
            hi_r  = int'($urandom_range(1, 6));
            if ($urandom_range(0, 2) != 0) tbl_write({pending_m, rw_r, reg_r}, 2'($urandom));
            bus({reg_r, 8'($urandom)}, rw_r, hi_r);
        end

        // Reset while holding enables.
        cfg_load(5'd3);
        address = 16'h20FF;
        rwbar   = 1'b0;
        phi2    = 1'b1;
        repeat (5) tick();
        chk("hold_enables", enables, ref_tbl[{5'd3, 1'b0, 8'h20}]);
        chk("hold_we", we, 1);
        reset = 1'b1;
        tick();
        chk("midrst_enables", enables, 0);
        chk("midrst_we", we, 0);
        chk("midrst_table_ready", table_ready, 0);
        chk("midrst_wr_ready", wr_ready, 0);
        phi2 = 1'b0;
        tick();
        init_count();
        tick();

        cfg_load(5'd7);
        bus(16'h4000, 1'b1, 4);
        cfg_load(5'd3);
        bus(16'h20FF, 1'b0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
